// File: rtl/apb4_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb4_slave_pkg
// Description : Shared types, limits and helpers for the parameterised APB4
//               register slave (FSM state type, byte-lane width function,
//               parameter legality limits).
// Revision    : 1.0 - initial release
// ============================================================================
package apb4_slave_pkg;

   // Access FSM states
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_t;

   // Parameter legality limits
   localparam int c_NUM_REGS_MIN = 1;
   localparam int c_NUM_REGS_MAX = 64;
   localparam int c_WAIT_CYC_MAX = 15;

   // Wait counter width, wide enough for c_WAIT_CYC_MAX
   localparam int c_WAIT_CNT_W   = 4;

   // Number of PADDR bits that select a byte within one data word
   function automatic int byte_lane_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage : apb4_slave_pkg
`default_nettype wire

// File: rtl/apb4_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : apb4_slave_regbank
// Description : Register storage for the APB4 slave: byte-strobe merge on
//               commit, read-only masking, read mux and one-cycle write
//               pulses issued the cycle after each commit.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_slave_regbank #(
   parameter int                  DATA_W   = 32,
   parameter int                  NUM_REGS = 8,
   parameter int                  IDX_W    = 10,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_wr_en,
   input  logic [IDX_W-1:0]             i_idx,
   input  logic [DATA_W/8-1:0]          i_strb,
   input  logic [DATA_W-1:0]            i_wdata,
   output logic [DATA_W-1:0]            o_rd_data,
   output logic                         o_ro_hit,
   output logic [NUM_REGS*DATA_W-1:0]   o_reg_q,
   output logic [NUM_REGS-1:0]          o_wr_pulse
);

   localparam int c_STRB_W = DATA_W / 8;

   // Read mux and read-only lookup for the addressed register; an index
   // outside the bank matches nothing and yields zero.
   always_comb begin
      o_rd_data = '0;
      o_ro_hit  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i_idx == IDX_W'(i)) begin
            o_rd_data = o_reg_q[i*DATA_W +: DATA_W];
            o_ro_hit  = RO_MASK[i];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_val;
      logic              r_pulse;
      logic              w_hit;

      // Read-only registers never take a write, even if commit is asserted
      assign w_hit = i_wr_en && (i_idx == IDX_W'(gi)) && !RO_MASK[gi];

      // Byte-merge storage update and the post-commit write pulse
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_val   <= '0;
            r_pulse <= 1'b0;
         end else begin
            r_pulse <= w_hit;
            if (w_hit) begin
               for (int b = 0; b < c_STRB_W; b++) begin
                  if (i_strb[b]) begin
                     r_val[b*8 +: 8] <= i_wdata[b*8 +: 8];
                  end
               end
            end
         end
      end

      assign o_reg_q[gi*DATA_W +: DATA_W] = r_val;
      assign o_wr_pulse[gi]               = r_pulse;
   end : g_reg

endmodule : apb4_slave_regbank
`default_nettype wire

// File: rtl/apb4_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : apb4_slave_param
// Description : Parameterised APB4 register slave. Two-state access FSM with
//               programmable wait states, address decode and error
//               detection; storage lives in apb4_slave_regbank.
//               Optional feature macro APB4_SLV_PPROT_CHECK_EN: when defined,
//               unprivileged writes (PPROT[0]=0) are rejected with PSLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_slave_param
   import apb4_slave_pkg::*;
#(
   parameter int                  DATA_W   = 32,
   parameter int                  ADDR_W   = 12,
   parameter int                  NUM_REGS = 8,
   parameter int                  WAIT_CYC = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [2:0]                 PPROT,
   input  logic [DATA_W/8-1:0]        PSTRB,
   input  logic [ADDR_W-1:0]          PADDR,
   input  logic [DATA_W-1:0]          PWDATA,
   output logic [DATA_W-1:0]          PRDATA,
   output logic                       PREADY,
   output logic                       PSLVERR,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]        wr_pulse
);

   localparam int c_BL    = byte_lane_bits(DATA_W);
   localparam int c_IDX_W = ADDR_W - c_BL;

   // Elaboration-time parameter legality checks
   if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
      $error("apb4_slave_param: DATA_W must be 8, 16 or 32");
   end
   if (NUM_REGS < c_NUM_REGS_MIN || NUM_REGS > c_NUM_REGS_MAX) begin : g_bad_num_regs
      $error("apb4_slave_param: NUM_REGS out of range");
   end
   if (WAIT_CYC < 0 || WAIT_CYC > c_WAIT_CYC_MAX) begin : g_bad_wait_cyc
      $error("apb4_slave_param: WAIT_CYC out of range");
   end

   apb_state_t              r_state;
   logic [c_WAIT_CNT_W-1:0] r_wait_cnt;

   logic [c_IDX_W-1:0] w_idx;
   logic [DATA_W-1:0]  w_rd_data;
   logic               w_ro_hit;
   logic               w_ready;
   logic               w_err;
   logic               w_err_range;
   logic               w_err_align;
   logic               w_err_ro;
   logic               w_err_rstrb;
   logic               w_err_prot;
   logic               w_wr_commit;

   assign w_idx = PADDR[ADDR_W-1:c_BL];

   // Sub-word address bits exist only when a word spans more than one byte
   if (c_BL > 0) begin : g_align_chk
      assign w_err_align = |PADDR[c_BL-1:0];
   end else begin : g_no_align_chk
      assign w_err_align = 1'b0;
   end

   assign w_err_range = (32'(w_idx) >= 32'(NUM_REGS));
   assign w_err_ro    = PWRITE && w_ro_hit;
   assign w_err_rstrb = !PWRITE && (|PSTRB);

`ifdef APB4_SLV_PPROT_CHECK_EN
   logic w_unused_pprot;
   assign w_unused_pprot = ^PPROT[2:1];
   assign w_err_prot     = PWRITE && !PPROT[0];
`else
   logic w_unused_pprot;
   assign w_unused_pprot = ^PPROT;
   assign w_err_prot     = 1'b0;
`endif

   assign w_err = w_err_range | w_err_align | w_err_ro | w_err_rstrb | w_err_prot;

   // Completion is combinational so zero-wait accesses finish in one cycle
   assign w_ready     = (r_state == ST_ACCESS) && PSEL && PENABLE &&
                        (r_wait_cnt == c_WAIT_CNT_W'(WAIT_CYC));
   assign w_wr_commit = w_ready && PWRITE && !w_err;

   assign PREADY  = w_ready;
   assign PSLVERR = w_ready && w_err;
   assign PRDATA  = (w_ready && !w_err && !PWRITE) ? w_rd_data : '0;

   // Access FSM and wait-state counter
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (PSEL && !PENABLE) begin
                  r_state    <= ST_ACCESS;
                  r_wait_cnt <= '0;
               end
            end
            ST_ACCESS: begin
               if (!PSEL || w_ready) begin
                  r_state <= ST_IDLE;
               end else if (PENABLE) begin
                  r_wait_cnt <= r_wait_cnt + c_WAIT_CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   apb4_slave_regbank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (c_IDX_W),
      .RO_MASK  (RO_MASK)
   ) u_regbank (
      .clk        (PCLK),
      .rst_n      (PRESETn),
      .i_wr_en    (w_wr_commit),
      .i_idx      (w_idx),
      .i_strb     (PSTRB),
      .i_wdata    (PWDATA),
      .o_rd_data  (w_rd_data),
      .o_ro_hit   (w_ro_hit),
      .o_reg_q    (reg_q),
      .o_wr_pulse (wr_pulse)
   );

endmodule : apb4_slave_param
`default_nettype wire

// File: doc/apb4_slave_param.md
APB4_SLAVE_PARAM -- requirements
Module: apb4_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width; legal values 8, 16, 32.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning PADDR width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning number of registers; legal range 1..64.
REQ-004 SHALL have parameter WAIT_CYC, default 0, meaning wait states inserted per access; legal range 0..15.
REQ-005 SHALL have parameter RO_MASK, default 0 (NUM_REGS bits); a set bit i makes register i read-only to APB.
REQ-006 SHALL have port PCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port PRESETn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have ports PSEL, PENABLE, PWRITE, each input, 1 bit: APB4 control.
REQ-009 SHALL have port PPROT, input, 3 bits: APB4 protection type.
REQ-010 SHALL have port PSTRB, input, DATA_W/8 bits: write byte strobes.
REQ-011 SHALL have port PADDR, input, ADDR_W bits: byte address.
REQ-012 SHALL have port PWDATA, input, DATA_W bits: write data.
REQ-013 SHALL have port PRDATA, output, DATA_W bits: read data.
REQ-014 SHALL have ports PREADY and PSLVERR, each output, 1 bit: APB4 completion and error.
REQ-015 SHALL have port reg_q, output, NUM_REGS*DATA_W bits: flattened register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-016 SHALL have port wr_pulse, output, NUM_REGS bits: one-cycle commit indication per register.

Function
REQ-017 SHALL decode the register index from PADDR[ADDR_W-1:BL], where BL = log2(DATA_W/8).
REQ-018 SHALL run a two-state FSM, IDLE and ACCESS, with transitions as follows:
- IDLE -> ACCESS when PSEL=1 and PENABLE=0.
- ACCESS -> IDLE on completion, or when PSEL=0.
REQ-019 SHALL hold a wait counter, cleared on entry to ACCESS, incremented each ACCESS cycle while PSEL=1, PENABLE=1 and PREADY=0.
REQ-020 SHALL assert PREADY combinationally when state=ACCESS, PSEL=1, PENABLE=1 and counter=WAIT_CYC; total access latency is WAIT_CYC+1 cycles after setup.
REQ-021 SHALL flag an error for any of the following:
- index >= NUM_REGS;
- PADDR[BL-1:0] != 0;
- write to a register whose RO_MASK bit is set;
- read with PSTRB != 0.
REQ-022 SHALL drive PSLVERR=1 only in the PREADY=1 cycle of an erroring access, else 0.
REQ-023 SHALL update, on a non-error write completion edge, only the bytes of the addressed register whose PSTRB bit is 1.
REQ-024 SHALL treat PSTRB=0 on a write as a successful no-op with no error.
REQ-025 SHALL drive PRDATA with the addressed register in the PREADY=1 cycle of a non-error read, and 0 in every other cycle.
REQ-026 SHALL assert wr_pulse[i] for exactly one cycle, the cycle after a non-error write completion to register i, including the PSTRB=0 case.
REQ-027 SHALL return to IDLE with no register change and no PREADY when PSEL drops during wait states.
REQ-028 SHALL support back-to-back transfers: a new setup phase in the cycle after completion re-enters ACCESS with the counter cleared.

Reset
REQ-029 SHALL, while PRESETn=0, force the FSM to IDLE, the counter to 0, all registers to 0, wr_pulse to 0, PREADY to 0, PSLVERR to 0 and PRDATA to 0.
REQ-030 SHALL abandon any in-flight access on reset assertion, with no partial register update.

Configuration
REQ-031 SHALL, with macro APB4_SLV_PPROT_CHECK_EN defined, flag writes with PPROT[0]=0 (unprivileged) as errors: PSLVERR=1 and no update.
REQ-032 SHALL, without APB4_SLV_PPROT_CHECK_EN, ignore PPROT entirely.

Structure
REQ-033 SHALL place the FSM state typedef, the byte-lane width function and the parameter legality limits in package apb4_slave_pkg.
REQ-034 SHALL implement register storage, byte-strobe merge, RO masking and wr_pulse generation in sub-module apb4_slave_regbank; the top holds the FSM, counter, decode and error logic.

Verification
REQ-035 SHALL cover a write-then-read: write 0xA5A5_1234, PSTRB=4'hF, to 0x004 -> PSLVERR=0, wr_pulse[1] pulses; read 0x004 -> PRDATA=0xA5A5_1234.
REQ-036 SHALL cover wait states: WAIT_CYC=3 -> PREADY low for 3 access cycles and high on the 4th; PSEL dropped at wait 2 -> no update, FSM returns to IDLE.
REQ-037 SHALL cover byte strobes: reg 2 holds 0x1122_3344; write 0xFFFF_FFFF with PSTRB=4'b0101 -> read returns 0x11FF_33FF.
REQ-038 SHALL cover error cases:
- address 0x020 with NUM_REGS=8 -> PSLVERR=1, PRDATA=0;
- address 0x002 -> PSLVERR=1;
- write to reg 0 with RO_MASK=1 -> PSLVERR=1, value unchanged.
REQ-039 SHALL cover reset mid-transfer: PRESETn low during an access -> all outputs 0 immediately, and all registers read 0 afterwards.
REQ-040 SHALL cover the PPROT check: with APB4_SLV_PPROT_CHECK_EN defined, write with PPROT=3'b000 -> PSLVERR=1 and no update; without the macro -> success.
